uart_tx_device: RTL and testbench

Memory-mapped serial transmitter on the processor data bus. It is the output-direction counterpart of the debounced switch input device and uses the same register style: data register, control/status register, ready/overrun bits, and a level IRQ.
Software writes a byte to the data register. The block buffers it in a one-entry holding register and shifts it out on TXD as 8N1 UART, LSB first.
IRQ signals "holding register empty" so an interrupt handler can stream bytes back-to-back.

---
 rtl/uart_dev_pkg.sv | 24 ++
 rtl/uart_tx_shifter.sv | 108 ++++++++++
 rtl/uart_tx_device.sv | 112 +++++++++++
 tb/tb_uart_tx_device.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dev_pkg.sv
// Shared definitions for the memory-mapped UART transmitter device.
// Holds the register offsets, the control/status bit positions and the
// shifter state encoding used by the top level and the shifter.
package uart_dev_pkg;

    // Register offsets relative to the data register address
    localparam int DATA_OFF = 0;
    localparam int CTRL_OFF = 4;

    // Control/status register bit positions
    localparam int READY   = 0;
    localparam int OVERRUN = 1;
    localparam int BUSY    = 2;
    localparam int IE      = 4;

    // Shifter state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 UART shift engine: start bit, 8 data bits LSB first, stop bit, each
// bit held for DIVISOR clock cycles.
//
// Ports:
//   CLK, RESET  clock, asynchronous active-high reset
//   load        level: a byte is waiting in the holding register
//   loadByte    the waiting byte
//   taken       pulse: loadByte is captured on this edge
//   state       current shifter state (also the busy indication)
//   TXD         registered serial output, idle high
//
// Handshake: load is a level request held by the owner of the byte;
// taken is high for exactly the cycle in which the shifter captures
// loadByte, and the owner drops load on that same edge.
module uart_tx_shifter
    import uart_dev_pkg::*;
#(
    parameter int DIVISOR = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] loadByte,
    output logic       taken,
    output txState_t   state,
    output logic       TXD
);

    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] RELOAD = CW'(DIVISOR - 1);

    logic [CW-1:0] baudCnt;
    logic [7:0]    shiftReg;
    logic [2:0]    bitIdx;
    logic          bitDone;

    assign bitDone = (baudCnt == '0);

    // A byte is captured either from idle or at the end of a stop bit, so
    // back-to-back frames have no idle gap between them.
    assign taken = load && ((state == IDLE) || ((state == STOP) && bitDone));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            TXD      <= 1'b1;
            baudCnt  <= '0;
            shiftReg <= '0;
            bitIdx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shiftReg <= loadByte;
                        baudCnt  <= RELOAD;
                        TXD      <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bitDone) begin
                        baudCnt <= RELOAD;
                        bitIdx  <= 3'd0;
                        TXD     <= shiftReg[0];
                        state   <= DATA;
                    end else begin
                        baudCnt <= baudCnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        baudCnt <= RELOAD;
                        if (bitIdx == 3'd7) begin
                            TXD   <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Next bit is shiftReg[1] before the shift lands
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            TXD      <= shiftReg[1];
                            bitIdx   <= bitIdx + 3'd1;
                        end
                    end else begin
                        baudCnt <= baudCnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bitDone) begin
                        if (load) begin
                            shiftReg <= loadByte;
                            baudCnt  <= RELOAD;
                            TXD      <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baudCnt <= baudCnt - 1'b1;
                    end
                end
                default: begin
                    TXD   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_device.sv
// Memory-mapped UART transmitter on the processor data bus.
// Software writes a byte to the data register; it waits in a one-entry
// holding register until the shifter takes it and sends it as 8N1.
//
// Ports:
//   CLK, RESET  clock, asynchronous active-high reset
//   ADDRBUS     bus address
//   DATABUS     bidirectional data bus, driven only during a read of this block
//   WE          1 = write, 0 = read
//   TXD         serial line, idle high
//   IRQ         level interrupt: holding register empty and IE set
//
// Control/status register: {0.., IE[4], 0[3], busy[2], overrun[1], ready[0]}
module uart_tx_device
    import uart_dev_pkg::*;
#(
    parameter int              BITS        = 32,
    parameter logic [BITS-1:0] BASE        = 32'hFFFF0140,
    parameter logic [BITS-1:0] CONTROLBASE = BASE + BITS'(CTRL_OFF),
    parameter int              CLK_FRQ     = 50000000,
    parameter int              BAUD        = 115200,
    parameter int              DIVISOR     = CLK_FRQ / BAUD
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] ADDRBUS,
    inout  wire  [BITS-1:0] DATABUS,
    input  logic            WE,
    output logic            TXD,
    output logic            IRQ
);

    logic            dataSel, ctrlSel;
    logic            dataWrite, ctrlWrite, readEn;
    logic [BITS-1:0] readData;
    logic [7:0]      holding;
    logic            ready, overrun, intEnable;
    logic            taken, busy;
    txState_t        shifterState;
    logic            unusedBusBits;

    assign dataSel   = (ADDRBUS == BASE);
    assign ctrlSel   = (ADDRBUS == CONTROLBASE);
    assign dataWrite = WE && dataSel;
    assign ctrlWrite = WE && ctrlSel;
    // Bus stays released while in reset, whatever the address says
    assign readEn    = !WE && (dataSel || ctrlSel) && !RESET;

    // Only a few write bits are stored; the rest are ignored on purpose
    assign unusedBusBits = ^DATABUS;

    assign busy = (shifterState != IDLE);
    assign IRQ  = ready && intEnable;

    always_comb begin
        readData = '0;
        if (ctrlSel) begin
            readData[READY]   = ready;
            readData[OVERRUN] = overrun;
            readData[BUSY]    = busy;
            readData[IE]      = intEnable;
        end else if (dataSel) begin
            readData[7:0] = holding;
        end
    end

    assign DATABUS = readEn ? readData : 'z;

    // A data write on the same edge the shifter takes the held byte still
    // sees ready==0, so it is dropped and flagged as overrun.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            holding   <= 8'h00;
            ready     <= 1'b1;
            overrun   <= 1'b0;
            intEnable <= 1'b0;
        end else begin
            if (taken) begin
                ready <= 1'b1;
            end else if (dataWrite && ready) begin
                ready <= 1'b0;
            end

            if (dataWrite && ready) begin
                holding <= DATABUS[7:0];
            end

            if (dataWrite && !ready) begin
                overrun <= 1'b1;
            end else if (ctrlWrite && !DATABUS[OVERRUN]) begin
                overrun <= 1'b0;
            end

            if (ctrlWrite) begin
                intEnable <= DATABUS[IE];
            end
        end
    end

    uart_tx_shifter #(
        .DIVISOR (DIVISOR)
    ) u_shifter (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (!ready),
        .loadByte (holding),
        .taken    (taken),
        .state    (shifterState),
        .TXD      (TXD)
    );

endmodule

// File: tb/tb_uart_tx_device.sv
module tb_uart_tx_device;

    localparam int          DIV   = 4;
    localparam logic [31:0] BASE  = 32'hFFFF0140;
    localparam logic [31:0] CBASE = 32'hFFFF0144;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        WE = 1'b0;
    logic [31:0] ADDRBUS = '0;
    logic        TXD, IRQ;
    logic        tbDrive = 1'b0;
    logic [31:0] tbData = '0;
    wire  [31:0] DATABUS;

    assign DATABUS = tbDrive ? tbData : 'z;

    uart_tx_device #(
        .BITS        (32),
        .BASE        (BASE),
        .CONTROLBASE (CBASE),
        .DIVISOR     (DIV)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ADDRBUS (ADDRBUS),
        .DATABUS (DATABUS),
        .WE      (WE),
        .TXD     (TXD),
        .IRQ     (IRQ)
    );

    // ---------------- clock / cycle count ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] expQ[$];
    int         startQ[$];
    int         wrCyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Line bit i of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic frameBit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    // ---------------- line receiver ----------------
    // Sample index 0 is the first low sample of a start bit; each bit is
    // sampled one cycle into its DIV-cycle window.
    logic       monEn = 1'b1;
    int         monCnt = -1;
    logic [7:0] rxByte = '0;

    always @(negedge CLK) begin
        if (!monEn || RESET) begin
            monCnt = -1;
        end else if (monCnt < 0) begin
            if (TXD == 1'b0) begin
                monCnt = 0;
                startQ.push_back(cyc);
            end
        end else begin
            monCnt++;
            if (monCnt % DIV == 1) begin
                if (monCnt / DIV == 0) begin
                    chk("rx_start_bit", TXD, 0);
                end else if (monCnt / DIV <= 8) begin
                    rxByte[monCnt / DIV - 1] = TXD;
                end else begin
                    chk("rx_stop_bit", TXD, 1);
                    chk("rx_frame_expected", (expQ.size() != 0), 1);
                    if (expQ.size() != 0) chk("rx_byte", rxByte, expQ.pop_front());
                end
            end
            if (monCnt == 10 * DIV - 1) monCnt = -1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        ADDRBUS = a; WE = 1'b1; tbData = d; tbDrive = 1'b1;
        @(posedge CLK);
        #1;
        wrCyc = cyc;
        ADDRBUS = '0; WE = 1'b0; tbDrive = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        @(negedge CLK);
        ADDRBUS = a; WE = 1'b0; tbDrive = 1'b0;
        #1;
        d = DATABUS;
        ADDRBUS = '0;
    endtask

    task automatic waitReady(input string tag);
        logic [31:0] r;
        logic        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            busRead(CBASE, r);
            if (r[0]) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1);
    endtask

    // Idle and empty: ready=1, busy=0; then every queued byte must have arrived
    task automatic drain(input string tag);
        logic [31:0] r;
        logic        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            busRead(CBASE, r);
            if ((r & 32'h5) == 32'h1) begin ok = 1'b1; break; end
        end
        chk({tag, "_idle"}, ok, 1);
        repeat (2) @(negedge CLK);
        chk({tag, "_drained"}, expQ.size(), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int          w1;

        // Power-on reset
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_txd", TXD, 1);
        chk("reset_irq", IRQ, 0);
        @(negedge CLK);
        RESET = 1'b0;
        busRead(CBASE, r); chk("reset_ctrl", r, 32'h1);
        busRead(BASE, r);  chk("reset_data", r, 32'h0);

        // Single byte: exact line waveform, busy and ready
        startQ.delete();
        expQ.push_back(8'hA5);
        busWrite(BASE, 32'hA5);
        busRead(CBASE, r); chk("ctrl_pending", r, 32'h0);
        for (int k = 0; k < 10 * DIV; k++) begin
            busRead(CBASE, r);
            chk("a5_txd", TXD, frameBit(8'hA5, k / DIV));
            chk("a5_ctrl_busy_ready", r, 32'h5);
        end
        busRead(BASE, r);  chk("a5_data_reg", r, 32'hA5);
        busRead(CBASE, r); chk("a5_ctrl_idle", r, 32'h1);
        chk("a5_txd_idle", TXD, 1);
        chk("a5_start_count", startQ.size(), 1);
        chk("a5_start_latency", (startQ.size() > 0) ? startQ[0] : -1, wrCyc + 1);

        // Back-to-back: second start bit directly after first stop bit
        startQ.delete();
        expQ.push_back(8'h55);
        busWrite(BASE, 32'h55);
        w1 = wrCyc;
        waitReady("b2b_ready");
        expQ.push_back(8'h0F);
        busWrite(BASE, 32'h0F);
        drain("b2b");
        chk("b2b_start_count", startQ.size(), 2);
        chk("b2b_first_start", (startQ.size() > 0) ? startQ[0] : -1, w1 + 1);
        chk("b2b_gap", (startQ.size() > 1) ? startQ[1] - startQ[0] : -1, 10 * DIV);

        // Overrun: second write on the next cycle is discarded
        expQ.push_back(8'h11);
        busWrite(BASE, 32'h11);
        busWrite(BASE, 32'h22);
        busRead(CBASE, r); chk("ovr_ctrl_set", r, 32'h7);
        busRead(BASE, r);  chk("ovr_data_kept", r, 32'h11);
        busWrite(CBASE, 32'h2);
        busRead(CBASE, r); chk("ovr_kept_by_bit1", r, 32'h7);
        busWrite(CBASE, 32'h0);
        busRead(CBASE, r); chk("ovr_cleared", r, 32'h5);
        drain("ovr");

        // IRQ follows ready when enabled
        busWrite(CBASE, 32'h10);
        busRead(CBASE, r); chk("irq_ctrl_ie", r, 32'h11);
        chk("irq_idle_high", IRQ, 1);
        b = 8'($urandom_range(0, 255));
        expQ.push_back(b);
        busWrite(BASE, {24'h0, b});
        chk("irq_low_after_write", IRQ, 0);
        @(posedge CLK);
        #1;
        chk("irq_high_after_load", IRQ, 1);
        drain("irq");
        busWrite(CBASE, 32'h0);
        chk("irq_disabled", IRQ, 0);
        busRead(CBASE, r); chk("irq_ctrl_off", r, 32'h1);

        // Random bytes, random gaps, occasional overrun attempts
        for (int t = 0; t < 8; t++) begin
            b = 8'($urandom_range(0, 255));
            waitReady("rnd_ready");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 30)) @(posedge CLK);
            expQ.push_back(b);
            busWrite(BASE, {24'h0, b});
            if ($urandom_range(0, 2) == 0) begin
                busWrite(BASE, {24'h0, ~b});
                busRead(CBASE, r); chk("rnd_overrun_set", r[1], 1);
                busWrite(CBASE, 32'h0);
                busRead(CBASE, r); chk("rnd_overrun_clr", r[1], 0);
            end
        end
        drain("rnd");

        // Reset during data bit 3 of 0xC3
        monEn = 1'b0;
        busWrite(CBASE, 32'h10);
        busWrite(BASE, 32'hC3);
        repeat (18) @(posedge CLK);
        #1;
        chk("mid_bit3_low", TXD, 0);
        #1;
        RESET = 1'b1;
        #1;
        chk("mid_reset_txd", TXD, 1);
        chk("mid_reset_irq", IRQ, 0);
        // Bus must be released while in reset even if addressed for a read
        ADDRBUS = CBASE; WE = 1'b0; tbData = 32'hA5A5A5A4; tbDrive = 1'b1;
        #1;
        chk("mid_reset_bus_released", DATABUS, 32'hA5A5A5A4);
        tbDrive = 1'b0; ADDRBUS = '0;
        @(negedge CLK);
        RESET = 1'b0;
        busRead(CBASE, r); chk("post_reset_ctrl", r, 32'h1);
        busRead(BASE, r);  chk("post_reset_data", r, 32'h0);
        chk("post_reset_txd", TXD, 1);
        monEn = 1'b1;
        expQ.push_back(8'h3C);
        busWrite(BASE, 32'h3C);
        drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
